// File: rtl/ram_block_server.sv
// ram_block_server: block-granular main-memory model sitting behind the cache.
// Serves one miss-fill and/or one dirty eviction at a time with fixed latency,
// and returns a whole block on a one-cycle ram_valid pulse.
//
// state | meaning
// IDLE  | sampling requests; write-back wins over fill when both are present
// WB    | counting down write latency; block committed when counter hits 0
// RD    | counting down read latency; block loaded into ram_data at 0
// RESP  | ram_valid high for this single cycle
// HOLD  | cache still holds its request level; inputs ignored
module ram_block_server #(
  parameter int RAM_ADDRESS_BITS = 10,
  parameter int DATA_BITS        = 32,
  parameter int BLOCK_BITS       = 2,
  parameter int READ_LATENCY     = 4,
  parameter int WRITE_LATENCY    = 3,
  localparam int BLOCK_SIZE      = 2 ** BLOCK_BITS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [RAM_ADDRESS_BITS-1:0] req_address,
  input  logic                        req_read_en,
  input  logic [RAM_ADDRESS_BITS-1:0] req_wb_address,
  input  logic [DATA_BITS-1:0]        req_write_data [BLOCK_SIZE-1:0],
  input  logic                        req_write_en,
  output logic                        ram_valid,
  output logic [DATA_BITS-1:0]        ram_data [BLOCK_SIZE-1:0],
  output logic                        busy
);

  localparam int DEPTH   = 2 ** RAM_ADDRESS_BITS;
  localparam int BLK_W   = RAM_ADDRESS_BITS - BLOCK_BITS;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WB, RD, RESP, HOLD} state_t;
  typedef logic [DATA_BITS-1:0] mem_t [DEPTH];

  // Power-up image: word a holds a, so fills are recognisable without preload.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = DATA_BITS'(i);
    return m;
  endfunction

  mem_t mem = init_mem();

  state_t               state, state_d;
  logic [CNT_W-1:0]     counter, counter_d;
  logic                 pending_rd, pending_d;
  logic [BLK_W-1:0]     rd_blk, rd_blk_d;
  logic [BLK_W-1:0]     wb_blk, wb_blk_d;
  logic [DATA_BITS-1:0] wb_data [BLOCK_SIZE-1:0];
  logic                 capture_wb;
  logic                 commit;
  logic                 load_data;

  // Word offsets within a block are don't-care on both request addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_address[BLOCK_BITS-1:0], req_wb_address[BLOCK_BITS-1:0]};

  assign busy      = (state != IDLE);
  assign ram_valid = (state == RESP);

  // Next-state, counter and capture decisions.
  always_comb begin
    state_d    = state;
    counter_d  = counter;
    pending_d  = pending_rd;
    rd_blk_d   = rd_blk;
    wb_blk_d   = wb_blk;
    capture_wb = 1'b0;
    commit     = 1'b0;
    load_data  = 1'b0;
    case (state)
      IDLE: begin
        if (req_write_en) begin
          capture_wb = 1'b1;
          wb_blk_d   = req_wb_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
          rd_blk_d   = req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
          pending_d  = req_read_en;
          counter_d  = WR_LOAD;
          state_d    = WB;
        end else if (req_read_en) begin
          rd_blk_d  = req_address[RAM_ADDRESS_BITS-1:BLOCK_BITS];
          counter_d = RD_LOAD;
          state_d   = RD;
        end
      end
      WB: begin
        if (counter == '0) begin
          commit = 1'b1;
          if (pending_rd) begin
            pending_d = 1'b0;
            counter_d = RD_LOAD;
            state_d   = RD;
          end else begin
            state_d = RESP;
          end
        end else begin
          counter_d = counter - CNT_W'(1);
        end
      end
      RD: begin
        if (counter == '0) begin
          load_data = 1'b1;
          state_d   = RESP;
        end else begin
          counter_d = counter - CNT_W'(1);
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and captured-request registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      pending_rd <= 1'b0;
      rd_blk     <= '0;
      wb_blk     <= '0;
      for (int k = 0; k < BLOCK_SIZE; k++) wb_data[k] <= '0;
    end else begin
      state      <= state_d;
      counter    <= counter_d;
      pending_rd <= pending_d;
      rd_blk     <= rd_blk_d;
      wb_blk     <= wb_blk_d;
      if (capture_wb) begin
        for (int k = 0; k < BLOCK_SIZE; k++) wb_data[k] <= req_write_data[k];
      end
    end
  end

  // Fill data register: only changes on the RD->RESP transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < BLOCK_SIZE; k++) ram_data[k] <= '0;
    end else if (load_data) begin
      for (int k = 0; k < BLOCK_SIZE; k++) ram_data[k] <= mem[{rd_blk, BLOCK_BITS'(k)}];
    end
  end

  // Memory array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int k = 0; k < BLOCK_SIZE; k++) mem[{wb_blk, BLOCK_BITS'(k)}] <= wb_data[k];
    end
  end

endmodule

// File: tb/tb_ram_block_server.sv
// tb_ram_block_server: directed and randomized checks of ram_block_server
// against a block-level memory model kept in the bench.
module tb_ram_block_server;

  localparam int RL = 4;
  localparam int WL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [9:0]  req_address, req_wb_address;
  logic        req_read_en, req_write_en;
  logic [31:0] req_write_data [3:0];
  logic        ram_valid, busy;
  logic [31:0] ram_data [3:0];

  logic [9:0]  f_req_address, f_req_wb_address;
  logic        f_req_read_en, f_req_write_en;
  logic [31:0] f_req_write_data [3:0];
  logic        f_ram_valid, f_busy;
  logic [31:0] f_ram_data [3:0];

  ram_block_server #(.READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_address(req_address), .req_read_en(req_read_en),
    .req_wb_address(req_wb_address), .req_write_data(req_write_data),
    .req_write_en(req_write_en),
    .ram_valid(ram_valid), .ram_data(ram_data), .busy(busy)
  );

  ram_block_server #(.READ_LATENCY(1), .WRITE_LATENCY(1)) dut_fast (
    .clk(clk), .reset_n(reset_n),
    .req_address(f_req_address), .req_read_en(f_req_read_en),
    .req_wb_address(f_req_wb_address), .req_write_data(f_req_write_data),
    .req_write_en(f_req_write_en),
    .ram_valid(f_ram_valid), .ram_data(f_ram_data), .busy(f_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: flat word memory plus the last block returned.
  logic [31:0] model_mem  [1024];
  logic [31:0] model_last [3:0];

  task automatic model_apply(input bit rd, input bit wr, input logic [9:0] a,
                             input logic [9:0] wa, input logic [31:0] wd [3:0],
                             output int exp_lat, output logic [31:0] exp_data [3:0]);
    int base;
    if (wr) begin
      base = int'(wa) & 32'h3FC;
      for (int k = 0; k < 4; k++) model_mem[base + k] = wd[k];
    end
    if (rd) begin
      base = int'(a) & 32'h3FC;
      for (int k = 0; k < 4; k++) model_last[k] = model_mem[base + k];
    end
    exp_data = model_last;
    exp_lat  = (wr ? WL : 0) + (rd ? RL : 0) + 1;
  endtask

  // Drives one request at a negedge and observes the response window.
  task automatic serve(input bit rd, input bit wr, input logic [9:0] a, input logic [9:0] wa,
                       input logic [31:0] wd [3:0], input bit hold,
                       output int lat, output int pulses, output int busy_cycles,
                       output logic busy_idle, output logic [31:0] got [3:0]);
    int n;
    lat = -1; pulses = 0; busy_cycles = 0; busy_idle = 1'bx; n = 0;
    for (int k = 0; k < 4; k++) got[k] = 'x;
    @(negedge clk);
    req_address = a; req_wb_address = wa; req_write_data = wd;
    req_read_en = rd; req_write_en = wr;
    while (n < 60 && lat < 0) begin
      @(negedge clk);
      n++;
      if (!hold) begin req_read_en = 1'b0; req_write_en = 1'b0; end
      if (busy === 1'b1) busy_cycles++;
      if (ram_valid === 1'b1) begin lat = n; pulses++; got = ram_data; end
    end
    @(negedge clk);
    if (busy === 1'b1) busy_cycles++;
    if (ram_valid === 1'b1) pulses++;
    req_read_en = 1'b0; req_write_en = 1'b0;
    @(negedge clk);
    busy_idle = busy;
    if (ram_valid === 1'b1) pulses++;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (ram_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ram_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram_data[k] !== 32'h0) $display("FAIL reset_data[%0d]: got %0h want 0", k, ram_data[k]); else n_pass++;
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0 || ram_valid !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 0/0", busy, ram_valid); else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    int lat, pulses, bc, el; logic bi;
    for (int k = 0; k < 4; k++) wd[k] = '0;
    model_apply(1, 0, 10'h013, 10'h0, wd, el, exp);
    serve(1, 0, 10'h013, 10'h0, wd, 0, lat, pulses, bc, bi, got);
    n_checks++; if (lat !== RL + 1) $display("FAIL read_latency: got %0d want %0d", lat, RL + 1); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL read_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (bc !== RL + 2) $display("FAIL read_busy_cycles: got %0d want %0d", bc, RL + 2); else n_pass++;
    n_checks++; if (bi !== 1'b0) $display("FAIL read_busy_idle: got %b want 0", bi); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL read_data[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
  endtask

  task automatic test_write_then_read();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    int lat, pulses, bc, el; logic bi;
    for (int k = 0; k < 4; k++) wd[k] = 32'hA0 + k;
    model_apply(0, 1, 10'h0, 10'h040, wd, el, exp);
    serve(0, 1, 10'h0, 10'h040, wd, 0, lat, pulses, bc, bi, got);
    n_checks++; if (lat !== WL + 1) $display("FAIL wr_latency: got %0d want %0d", lat, WL + 1); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL wr_keeps_data[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
    model_apply(1, 0, 10'h042, 10'h0, wd, el, exp);
    serve(1, 0, 10'h042, 10'h0, wd, 0, lat, pulses, bc, bi, got);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL wr_readback[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    int lat, pulses, bc, el; logic bi;
    for (int k = 0; k < 4; k++) wd[k] = 32'hB0 + k;
    model_apply(1, 1, 10'h100, 10'h080, wd, el, exp);
    serve(1, 1, 10'h100, 10'h080, wd, 0, lat, pulses, bc, bi, got);
    n_checks++; if (lat !== WL + RL + 1) $display("FAIL both_latency: got %0d want %0d", lat, WL + RL + 1); else n_pass++;
    n_checks++; if (pulses !== 1) $display("FAIL both_pulses: got %0d want 1", pulses); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL both_data[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
    model_apply(1, 0, 10'h080, 10'h0, wd, el, exp);
    serve(1, 0, 10'h080, 10'h0, wd, 0, lat, pulses, bc, bi, got);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL both_readback[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
    // Same block written and filled together: fill must see the new data.
    for (int k = 0; k < 4; k++) wd[k] = 32'h5150_0000 + k;
    model_apply(1, 1, 10'h141, 10'h142, wd, el, exp);
    serve(1, 1, 10'h141, 10'h142, wd, 0, lat, pulses, bc, bi, got);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL same_block[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
  endtask

  task automatic test_level_hold();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    int lat, pulses, bc, el, n, p1, p2, extra; logic bi;
    for (int k = 0; k < 4; k++) wd[k] = '0;
    model_apply(1, 0, 10'h1C5, 10'h0, wd, el, exp);
    serve(1, 0, 10'h1C5, 10'h0, wd, 1, lat, pulses, bc, bi, got);
    n_checks++; if (pulses !== 1) $display("FAIL hold_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (lat !== RL + 1) $display("FAIL hold_latency: got %0d want %0d", lat, RL + 1); else n_pass++;
    n_checks++; if (bi !== 1'b0) $display("FAIL hold_busy_idle: got %b want 0", bi); else n_pass++;
    // Level never dropped: second accept happens in the first IDLE after HOLD.
    model_apply(1, 0, 10'h200, 10'h0, wd, el, exp);
    @(negedge clk);
    req_address = 10'h200; req_read_en = 1'b1;
    n = 0; p1 = -1; p2 = -1;
    while (n < 60 && p2 < 0) begin
      @(negedge clk);
      n++;
      if (ram_valid === 1'b1) begin
        if (p1 < 0) p1 = n; else p2 = n;
      end
    end
    req_read_en = 1'b0;
    n_checks++; if (p1 !== RL + 1) $display("FAIL held_first: got %0d want %0d", p1, RL + 1); else n_pass++;
    n_checks++; if (p2 - p1 !== RL + 3) $display("FAIL held_spacing: got %0d want %0d", p2 - p1, RL + 3); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram_data[k] !== exp[k]) $display("FAIL held_data[%0d]: got %0h want %0h", k, ram_data[k], exp[k]); else n_pass++;
    end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ram_valid === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL held_extra_pulses: got %0d want 0", extra); else n_pass++;
  endtask

  task automatic test_reset_mid_wb();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    int lat, pulses, bc, el, extra; logic bi;
    @(negedge clk);
    req_wb_address = 10'h0C0; req_write_en = 1'b1;
    for (int k = 0; k < 4; k++) req_write_data[k] = 32'hDEAD_0000 + k;
    @(negedge clk);
    req_write_en = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_in_wb: got busy=%b want 1", busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (ram_data[k] !== 32'h0) $display("FAIL abort_data[%0d]: got %0h want 0", k, ram_data[k]); else n_pass++;
    end
    for (int k = 0; k < 4; k++) model_last[k] = '0;
    @(negedge clk); reset_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_valid === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) $display("FAIL abort_pulses: got %0d want 0", extra); else n_pass++;
    for (int k = 0; k < 4; k++) wd[k] = '0;
    model_apply(1, 0, 10'h0C0, 10'h0, wd, el, exp);
    serve(1, 0, 10'h0C0, 10'h0, wd, 0, lat, pulses, bc, bi, got);
    n_checks++; if (lat !== RL + 1) $display("FAIL abort_read_latency: got %0d want %0d", lat, RL + 1); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== exp[k]) $display("FAIL abort_untouched[%0d]: got %0h want %0h", k, got[k], exp[k]); else n_pass++;
    end
  endtask

  task automatic test_fast_latency();
    int n, lat;
    logic [31:0] got [3:0];
    for (int k = 0; k < 4; k++) got[k] = 'x;
    @(negedge clk);
    f_req_address = 10'h3FF; f_req_read_en = 1'b1;
    n = 0; lat = -1;
    while (n < 20 && lat < 0) begin
      @(negedge clk);
      n++;
      f_req_read_en = 1'b0;
      if (f_ram_valid === 1'b1) begin lat = n; got = f_ram_data; end
    end
    n_checks++; if (lat !== 2) $display("FAIL fast_latency: got %0d want 2", lat); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (got[k] !== 32'h3FC + k) $display("FAIL fast_data[%0d]: got %0h want %0h", k, got[k], 32'h3FC + k); else n_pass++;
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] wd [3:0], got [3:0], exp [3:0];
    logic [9:0] a, wa;
    int lat, pulses, bc, el, kind;
    bit rd, wr;
    logic bi;
    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      a  = 10'($urandom_range(0, (it % 2 == 0) ? 127 : 1023));
      wa = 10'($urandom_range(0, 127));
      for (int k = 0; k < 4; k++) wd[k] = $urandom();
      model_apply(rd, wr, a, wa, wd, el, exp);
      serve(rd, wr, a, wa, wd, it % 3 == 0, lat, pulses, bc, bi, got);
      n_checks++; if (lat !== el) $display("FAIL rand_latency it=%0d: got %0d want %0d", it, lat, el); else n_pass++;
      n_checks++; if (pulses !== 1) $display("FAIL rand_pulses it=%0d: got %0d want 1", it, pulses); else n_pass++;
      n_checks++; if (bc !== el + 1) $display("FAIL rand_busy it=%0d: got %0d want %0d", it, bc, el + 1); else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (got[k] !== exp[k]) $display("FAIL rand_data it=%0d [%0d]: got %0h want %0h", it, k, got[k], exp[k]); else n_pass++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req_address = '0; req_wb_address = '0; req_read_en = 1'b0; req_write_en = 1'b0;
    f_req_address = '0; f_req_wb_address = '0; f_req_read_en = 1'b0; f_req_write_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_write_data[k] = '0;
      f_req_write_data[k] = '0;
      model_last[k] = '0;
    end
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i);

    test_reset();
    test_read();
    test_write_then_read();
    test_simultaneous();
    test_level_hold();
    test_reset_mid_wb();
    test_fast_latency();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
